// File: rtl/seq_serial_pkg.sv
// Shared types and line levels for the serial byte link (transmitter and receiver).
package seq_serial_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/seq_baud_tick.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT-cycle bit period.
module seq_baud_tick
   import seq_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   if (CLKS_PER_BIT < 1) begin : g_param_check
      $error("seq_baud_tick: CLKS_PER_BIT must be >= 1");
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/seq_byte_serializer.sv
// Framed parallel-to-serial transmitter: start bit, DATA_WIDTH bits LSB-first, stop bit.
//
// state | meaning
// IDLE  | line high, in_ready high, waiting for a word
// START | line low for one bit period
// DATA  | line = shift_reg[0], one bit period per data bit
// STOP  | line high for one bit period, tx_done on its last cycle
module seq_byte_serializer
   import seq_serial_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  tx_line,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   ser_state_t            state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [BW-1:0]         bit_idx;
   logic                  tick;
   logic                  clear;

   if (DATA_WIDTH < 1 || CLKS_PER_BIT < 1) begin : g_param_check
      $error("seq_byte_serializer: DATA_WIDTH and CLKS_PER_BIT must be >= 1");
   end

   // Holding the timer clear in IDLE aligns every bit period to the handshake edge.
   assign clear     = (state == IDLE);
   assign shift_nxt = shift_reg >> 1;

   seq_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx_line   <= LINE_IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= in_data;
                  bit_idx   <= '0;
                  tx_line   <= LINE_START;
                  state     <= START;
               end
            end
            START: begin
               if (tick) begin
                  bit_idx <= '0;
                  tx_line <= shift_reg[0];
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     tx_line <= LINE_IDLE;
                     state   <= STOP;
                  end else begin
                     bit_idx   <= bit_idx + 1'b1;
                     shift_reg <= shift_nxt;
                     tx_line   <= shift_nxt[0];
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  tx_line <= LINE_IDLE;
                  state   <= IDLE;
               end
            end
            default: begin
               tx_line <= LINE_IDLE;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign tx_busy  = (state != IDLE);
   assign tx_done  = (state == STOP) && tick;

endmodule

// File: tb/tb_seq_byte_serializer.sv
// Directed bench for seq_byte_serializer: default instance plus a CLKS_PER_BIT=1 instance.
module tb_seq_byte_serializer;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, tx_line, tx_busy, tx_done;
   logic [7:0] in_data;
   logic       rst1, in_valid1, in_ready1, tx_line1, tx_busy1, tx_done1;
   logic [7:0] in_data1;

   int   vectors     = 0;
   int   miscompares = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   seq_byte_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   seq_byte_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .tx_line(tx_line1), .tx_busy(tx_busy1), .tx_done(tx_done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {line, ready, busy, done}
   function automatic logic [3:0] outs(input int sel);
      if (sel == 0) return {tx_line, in_ready, tx_busy, tx_done};
      return {tx_line1, in_ready1, tx_busy1, tx_done1};
   endfunction

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      if (sel == 0) begin
         in_valid = v;
         in_data  = d;
      end else begin
         in_valid1 = v;
         in_data1  = d;
      end
   endtask

   task automatic check_idle(input int sel, input string tag);
      logic [3:0] o;
      o = outs(sel);
      chk({tag, ".line"},  32'(o[3]), 32'd1);
      chk({tag, ".ready"}, 32'(o[2]), 32'd1);
      chk({tag, ".busy"},  32'(o[1]), 32'd0);
      chk({tag, ".done"},  32'(o[0]), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge of frame cycle 1.
   task automatic handshake(input int sel, input logic [7:0] w, input string tag);
      logic [3:0] o;
      int         n = 0;
      drive(sel, 1'b1, w);
      o = outs(sel);
      while (o[2] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         o = outs(sel);
      end
      chk({tag, ".hs_ready"}, 32'(o[2]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, w);
   endtask

   // Starts at the negedge of frame cycle 1; ends at the negedge after the frame.
   task automatic frame(input int sel, input logic [7:0] w, input logic offer,
                        input logic [7:0] od, input int abort_at, input string tag);
      int         cpb;
      int         len;
      logic [3:0] o;
      cpb = (sel == 0) ? 4 : 1;
      len = 10 * cpb;
      exp_q.delete();
      for (int k = 0; k < cpb; k++) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < cpb; k++) exp_q.push_back(w[b]);
      for (int k = 0; k < cpb; k++) exp_q.push_back(1'b1);
      for (int c = 1; c <= len; c++) begin
         o = outs(sel);
         chk($sformatf("%s.line.c%0d", tag, c),  32'(o[3]), 32'(exp_q.pop_front()));
         chk($sformatf("%s.ready.c%0d", tag, c), 32'(o[2]), 32'd0);
         chk($sformatf("%s.busy.c%0d", tag, c),  32'(o[1]), 32'd1);
         chk($sformatf("%s.done.c%0d", tag, c),  32'(o[0]), 32'(c == len));
         if (c == abort_at) begin
            drive(sel, 1'b0, od);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_idle(sel, {tag, ".abort"});
            for (int k = 0; k < 45; k++) begin
               @(negedge clk);
               o = outs(sel);
               chk($sformatf("%s.post_abort.done%0d", tag, k), 32'(o[0]), 32'd0);
               chk($sformatf("%s.post_abort.line%0d", tag, k), 32'(o[3]), 32'd1);
            end
            exp_q.delete();
            return;
         end
         drive(sel, offer, od);
         @(negedge clk);
      end
      check_idle(sel, {tag, ".gap"});
   endtask

   initial begin
      rst  = 1'b1;
      rst1 = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      check_idle(0, "reset");
      check_idle(1, "reset1");
      rst  = 1'b0;
      rst1 = 1'b0;
      @(negedge clk);

      // Single frame with defaults
      handshake(0, 8'hA5, "t1");
      frame(0, 8'hA5, 1'b0, 8'h00, 0, "t1");

      // Back-to-back with in_valid held: second word accepted right after the gap cycle
      handshake(0, 8'h00, "t2a");
      frame(0, 8'h00, 1'b1, 8'hFF, 0, "t2a");
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      frame(0, 8'hFF, 1'b0, 8'h00, 0, "t2b");

      // Offer during a busy frame is ignored, then accepted after tx_done
      handshake(0, 8'h5A, "t3a");
      frame(0, 8'h5A, 1'b1, 8'h3C, 0, "t3a");
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      frame(0, 8'h3C, 1'b0, 8'h00, 0, "t3b");

      // Reset during DATA bit 3 (cycle 17), then a clean frame
      handshake(0, 8'hC3, "t4a");
      frame(0, 8'hC3, 1'b0, 8'h00, 17, "t4a");
      handshake(0, 8'h81, "t4b");
      frame(0, 8'h81, 1'b0, 8'h00, 0, "t4b");

      // Reset held 3 cycles with in_valid high: no handshake until release
      drive(0, 1'b1, 8'h66);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_idle(0, $sformatf("t6.rst%0d", k));
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      frame(0, 8'h66, 1'b0, 8'h00, 0, "t6");

      // One clock per bit
      handshake(1, 8'h81, "t5");
      frame(1, 8'h81, 1'b0, 8'h00, 0, "t5");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
